pla_seq_eval: RTL and testbench

- Programmable, sequential sum-of-products evaluator; parametrised successor to the fixed per-benchmark PLA modules.
- The product-term table (input cubes plus output masks) is loaded at run time through a config port, not hard-wired.
- Accepts one input vector per transaction and sweeps the term table TERMS_PER_CYC terms per cycle.
- Returns the OR-plane result through a valid/ready handshake; sits between a benchmark stimulus source and a result checker or consumer.

---
 rtl/pla_seq_eval.sv | 134 +++++++++++++
 tb/tb_pla_seq_eval.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pla_seq_eval.sv
// Programmable sequential sum-of-products evaluator: sweeps a run-time loaded
// term table TERMS_PER_CYC terms per cycle. Optional macro PLA_OUTPUT_PHASE_EN adds an output phase register.
module pla_seq_eval #(
  parameter int N_IN          = 29,
  parameter int N_OUT         = 7,
  parameter int N_TERMS       = 64,
  parameter int TERMS_PER_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic                       cfg_clr,
  input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
  input  logic [N_IN-1:0]            cfg_care,
  input  logic [N_IN-1:0]            cfg_val,
  input  logic [N_OUT-1:0]           cfg_out,
`ifdef PLA_OUTPUT_PHASE_EN
  input  logic                       cfg_phase_we,
  input  logic [N_OUT-1:0]           cfg_phase,
`endif
  output logic                       cfg_ready,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_z,
  output logic                       busy
);
  localparam int AW = $clog2(N_TERMS);
  localparam int K  = N_TERMS / TERMS_PER_CYC;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state;

  logic [N_IN-1:0]    care_m [N_TERMS];
  logic [N_IN-1:0]    val_m  [N_TERMS];
  logic [N_OUT-1:0]   out_m  [N_TERMS];
  logic [N_TERMS-1:0] term_en;
  logic [N_IN-1:0]    x_q;
  logic [N_OUT-1:0]   acc;
  logic [CW-1:0]      chunk;
  logic [N_OUT-1:0]   phase_q;

  logic idle, addr_ok, wr_ok, err_c;
  logic [TERMS_PER_CYC-1:0][N_OUT-1:0] lane_z;
  logic [N_OUT-1:0] chunk_z;

  assign idle      = (state == IDLE);
  assign cfg_ready = idle;
  assign in_ready  = idle;
  assign busy      = !idle;
  // Out-of-range addresses only exist when N_TERMS is not a power of two.
  assign addr_ok   = 32'(cfg_addr) < 32'(N_TERMS);
  assign wr_ok     = idle && cfg_we && !cfg_clr && addr_ok;

  always_comb begin
    err_c = (!idle && (cfg_we || cfg_clr)) || (idle && cfg_we && !cfg_clr && !addr_ok);
`ifdef PLA_OUTPUT_PHASE_EN
    err_c = err_c || (!idle && cfg_phase_we);
`endif
  end

  // Term storage is deliberately not reset; term_en alone gates validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      care_m[cfg_addr] <= cfg_care;
      val_m[cfg_addr]  <= cfg_val;
      out_m[cfg_addr]  <= cfg_out;
    end
  end

`ifdef PLA_OUTPUT_PHASE_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                    phase_q <= '0;
    else if (idle && cfg_phase_we) phase_q <= cfg_phase;
  end
`else
  assign phase_q = '0;
`endif

  for (genvar i = 0; i < TERMS_PER_CYC; i++) begin : g_lane
    logic [AW-1:0] t;
    assign t = AW'(int'(chunk) * TERMS_PER_CYC + i);
    assign lane_z[i] = (term_en[t] && ((x_q ^ val_m[t]) & care_m[t]) == '0) ? out_m[t] : '0;
  end

  always_comb begin
    chunk_z = '0;
    for (int i = 0; i < TERMS_PER_CYC; i++) chunk_z = chunk_z | lane_z[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_z     <= '0;
      cfg_err   <= 1'b0;
      term_en   <= '0;
      x_q       <= '0;
      acc       <= '0;
      chunk     <= '0;
    end else begin
      cfg_err <= err_c;
      if (idle && cfg_clr) term_en <= '0;
      else if (wr_ok)      term_en[cfg_addr] <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          x_q   <= in_x;
          acc   <= '0;
          chunk <= '0;
          state <= EVAL;
        end
        EVAL: begin
          acc <= acc | chunk_z;
          if (chunk == CW'(K - 1)) begin
            out_z     <= (acc | chunk_z) ^ phase_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pla_seq_eval.sv
// Bench for pla_seq_eval: table-driven vectors through a result scoreboard,
// plus hand-written hold, config-drop, clear and mid-eval reset sequences.
module tb_pla_seq_eval;
  localparam int N_IN = 29, N_OUT = 7, N_TERMS = 64, TPC = 4, K = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_clr = 1'b0;
  logic [5:0] cfg_addr = '0;
  logic [N_IN-1:0] cfg_care = '0, cfg_val = '0;
  logic [N_OUT-1:0] cfg_out = '0;
  logic cfg_ready, cfg_err, in_ready, out_valid, busy;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [N_IN-1:0] in_x = '0;
  logic [N_OUT-1:0] out_z;
`ifdef PLA_OUTPUT_PHASE_EN
  logic cfg_phase_we = 1'b0;
  logic [N_OUT-1:0] cfg_phase = '0;
`endif

  pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .TERMS_PER_CYC(TPC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_addr(cfg_addr),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out),
`ifdef PLA_OUTPUT_PHASE_EN
    .cfg_phase_we(cfg_phase_we), .cfg_phase(cfg_phase),
`endif
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [N_OUT-1:0] sb[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic cfg_write(int addr, logic [N_IN-1:0] care, logic [N_IN-1:0] val, logic [N_OUT-1:0] o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_care = care; cfg_val = val; cfg_out = o;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle_write", cfg_err, 0);
  endtask

  task automatic accept(logic [N_IN-1:0] x, logic [N_OUT-1:0] exp);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_x = x;
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0; in_x = N_IN'($urandom);
  endtask

  task automatic wait_result(string name);
    int n;
    logic [N_OUT-1:0] exp;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({name, "_latency"}, n, K);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check(name, out_z, exp);
    end
  endtask

  task automatic release_result(string name);
    logic [N_OUT-1:0] z;
    z = out_z;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_clr"}, out_valid, 0);
    check({name, "_z_held"}, out_z, z);
  endtask

  task automatic run(logic [N_IN-1:0] x, logic [N_OUT-1:0] exp, string name);
    accept(x, exp);
    wait_result(name);
    release_result(name);
  endtask

  task automatic apply_stage(int s);
    if (s == 1) cfg_write(0, 29'(1 << 4), 29'(1 << 4), 7'h40);
    if (s == 2) begin
      cfg_write(63, '0, '0, 7'h01);
      cfg_write(5, 29'((1 << 12) | (1 << 15)), 29'(1 << 12), 7'h02);
    end
  endtask

  typedef struct {
    int               stage;
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] z;
    string            nm;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bit ok;
    int cur;
    tbl[0] = '{0, 29'(0), 7'h00, "empty"};
    tbl[1] = '{1, 29'(1 << 4), 7'h40, "t0_hit"};
    tbl[2] = '{1, 29'(0), 7'h00, "t0_miss"};
    tbl[3] = '{2, 29'(1 << 12), 7'h03, "t5_hit"};
    tbl[4] = '{2, 29'((1 << 12) | (1 << 15)), 7'h01, "t5_miss"};
    tbl[5] = '{2, 29'((1 << 4) | (1 << 12)), 7'h43, "t0_t5"};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    cur = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].stage != cur) begin apply_stage(tbl[i].stage); cur = tbl[i].stage; end
      run(tbl[i].x, tbl[i].z, tbl[i].nm);
    end

    // Hold the result 10 cycles; a write attempted meanwhile must be dropped.
    accept(29'(1 << 12), 7'h03);
    wait_result("hold");
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin cfg_we = 1'b1; cfg_addr = 6'd1; cfg_care = '0; cfg_val = '0; cfg_out = 7'h10; end
      if (c == 4) begin cfg_we = 1'b0; check("drop_err_pulse", cfg_err, 1); end
      if (c == 5) check("drop_err_one_cycle", cfg_err, 0);
      if (!(out_valid && out_z == 7'h03 && !in_ready && !cfg_ready && busy)) ok = 1'b0;
    end
    check("hold_stable", ok, 1);
    release_result("hold");
    run(29'(1 << 12), 7'h03, "post_drop");

    // Write and acceptance on the same edge: evaluation sees the new term.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'd7; cfg_care = '0; cfg_val = '0; cfg_out = 7'h20;
    in_valid = 1'b1; in_x = '0;
    sb.push_back(7'h21);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    check("same_edge_err", cfg_err, 0);
    wait_result("same_edge");
    release_result("same_edge");

    // Clear wins over a simultaneous write, without an error.
    @(negedge clk);
    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd2; cfg_care = '0; cfg_out = 7'h08;
    @(negedge clk);
    cfg_clr = 1'b0; cfg_we = 1'b0;
    check("clr_we_err", cfg_err, 0);
    run(29'(1 << 12), 7'h00, "after_clr");

    // Reset in the middle of an evaluation abandons it.
    cfg_write(63, '0, '0, 7'h01);
    run('0, 7'h01, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; in_x = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_z", out_z, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("mid_rst_no_result", ok, 1);
    run('0, 7'h00, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
